// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int INSTRUCTION_WIDTH = 32;
  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    WAIT,
    HOLD,
    DRAIN,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-pc select for the fetch stage: hold, sequential step or redirect.
// FETCH_MISALIGN_TRAP_EN keeps misaligned targets raw and flags them.
module fetch_pc_next
  import fetch_pkg::*;
#(
  parameter int unsigned PC_INCREMENT = 4
) (
  input  logic [31:0] pc,
  input  logic        redirect,
  input  logic        advance,
  input  logic [31:0] next_pc,
  output logic [31:0] pc_next,
  output logic        misaligned
);

  logic [INSTRUCTION_WIDTH-1:0] target;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target     = next_pc;
  assign misaligned = redirect && (next_pc[1:0] != 2'b00);
`else
  assign target     = {next_pc[31:2], 2'b00};
  assign misaligned = 1'b0;
`endif

  always_comb begin
    pc_next = pc;
    unique case (1'b1)
      redirect: pc_next = target;
      advance:  pc_next = pc + 32'(PC_INCREMENT);
      default:  pc_next = pc;
    endcase
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: one outstanding imem request, redirect handling.
// Optional macro FETCH_MISALIGN_TRAP_EN halts on a misaligned redirect.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned PC_INCREMENT = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_request_valid,
  input  logic        imem_request_ready,
  output logic [31:0] imem_request_address,
  input  logic        imem_response_valid,
  input  logic [31:0] imem_response_data,
  output logic        instruction_valid,
  input  logic        instruction_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  input  logic        next_pc_valid,
  input  logic [31:0] next_pc,
  output logic        fetch_misaligned
);

  fetch_state_t state;
  fetch_state_t state_next;
  logic [31:0]  pc_next;
  logic         redirect;
  logic         advance;
  logic         capture;
  logic         trap;

  assign redirect = next_pc_valid &&
    (state inside {REQUEST, WAIT, DRAIN, HOLD});
  assign advance = (state == HOLD) &&
    instruction_ready && !next_pc_valid;

  assign imem_request_valid   = (state == REQUEST);
  assign imem_request_address = pc;
  assign instruction_valid    = (state == HOLD);

  fetch_pc_next #(
    .PC_INCREMENT(PC_INCREMENT)
  ) u_pc_next (
    .pc        (pc),
    .redirect  (redirect),
    .advance   (advance),
    .next_pc   (next_pc),
    .pc_next   (pc_next),
    .misaligned(trap)
  );

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    unique case (state)
      IDLE: state_next = REQUEST;
      REQUEST: begin
        if (imem_request_ready)
          state_next = redirect ? DRAIN : WAIT;
      end
      WAIT: begin
        if (imem_response_valid && !redirect) begin
          capture    = 1'b1;
          state_next = HOLD;
        end else if (imem_response_valid) begin
          state_next = REQUEST;
        end else if (redirect) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_response_valid)
          state_next = REQUEST;
      end
      HOLD: begin
        if (redirect || instruction_ready)
          state_next = REQUEST;
      end
      HALT: state_next = HALT;
      default: state_next = IDLE;
    endcase
    // A misaligned target is never fetched
    if (trap)
      state_next = HALT;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_VECTOR;
      instruction <= NOP_INSTRUCTION;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (capture)
        instruction <= imem_response_data;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clock) begin
    if (!reset_n)
      fetch_misaligned <= 1'b0;
    else if (trap)
      fetch_misaligned <= 1'b1;
  end
`else
  assign fetch_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: memory model, pc model, directed cases.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        imem_request_valid;
  logic        imem_request_ready;
  logic [31:0] imem_request_address;
  logic        imem_response_valid;
  logic [31:0] imem_response_data;
  logic        instruction_valid;
  logic        instruction_ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        next_pc_valid;
  logic [31:0] next_pc;
  logic        fetch_misaligned;

  logic        w_req_valid;
  logic        w_req_ready = 1'b1;
  logic [31:0] w_req_address;
  logic        w_resp_valid = 1'b0;
  logic [31:0] w_resp_data = 32'h0;
  logic        w_instr_valid;
  logic        w_instr_ready = 1'b1;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic        w_npc_valid = 1'b0;
  logic [31:0] w_npc = 32'h0;
  logic        w_misaligned;

  always #5 clock = ~clock;

  instruction_fetch u_dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .imem_request_valid  (imem_request_valid),
    .imem_request_ready  (imem_request_ready),
    .imem_request_address(imem_request_address),
    .imem_response_valid (imem_response_valid),
    .imem_response_data  (imem_response_data),
    .instruction_valid   (instruction_valid),
    .instruction_ready   (instruction_ready),
    .instruction         (instruction),
    .pc                  (pc),
    .next_pc_valid       (next_pc_valid),
    .next_pc             (next_pc),
    .fetch_misaligned    (fetch_misaligned)
  );

  instruction_fetch #(
    .RESET_VECTOR(32'hFFFF_FFFC)
  ) u_wrap (
    .clock               (clock),
    .reset_n             (reset_n),
    .imem_request_valid  (w_req_valid),
    .imem_request_ready  (w_req_ready),
    .imem_request_address(w_req_address),
    .imem_response_valid (w_resp_valid),
    .imem_response_data  (w_resp_data),
    .instruction_valid   (w_instr_valid),
    .instruction_ready   (w_instr_ready),
    .instruction         (w_instr),
    .pc                  (w_pc),
    .next_pc_valid       (w_npc_valid),
    .next_pc             (w_npc),
    .fetch_misaligned    (w_misaligned)
  );

  int n_checks = 0;
  int n_fail = 0;
  int mem_lat = 1;
  int n_valid = 0;
  logic outstanding = 1'b0;
  logic [31:0] req_log[$];
  logic [31:0] cons_log[$];
  logic [31:0] w_req_log[$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    if (i < q.size())
      return q[i];
    return 'x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: accepts a request, answers after mem_lat cycles with word_at(addr)
  initial begin : memory
    logic acc, fire, rst;
    logic [31:0] a, pend;
    int cnt;
    imem_response_valid = 1'b0;
    imem_response_data  = 32'h0;
    pend = 32'h0;
    cnt = 0;
    forever begin
      @(negedge clock);
      acc  = imem_request_valid && imem_request_ready && reset_n;
      a    = imem_request_address;
      fire = imem_response_valid;
      rst  = !reset_n;
      @(posedge clock);
      #1;
      if (rst) begin
        outstanding = 1'b0;
        imem_response_valid = 1'b0;
      end else begin
        if (fire) begin
          imem_response_valid = 1'b0;
          outstanding = 1'b0;
        end
        if (acc) begin
          outstanding = 1'b1;
          pend = a;
          cnt = mem_lat;
          req_log.push_back(a);
        end
        if (outstanding && !imem_response_valid) begin
          if (cnt <= 1) begin
            imem_response_valid = 1'b1;
            imem_response_data  = word_at(pend);
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  initial begin : wrap_memory
    logic acc;
    logic [31:0] a;
    forever begin
      @(negedge clock);
      acc = w_req_valid && reset_n;
      a = w_req_address;
      @(posedge clock);
      #1;
      w_resp_valid = acc;
      if (acc) begin
        w_resp_data = word_at(a);
        w_req_log.push_back(a);
      end
    end
  end

  // Architectural model: pc advances on consume, jumps on redirect
  logic [31:0] model_pc;
  logic        model_mis;
  logic        model_halt;
  logic        hold_pend;
  logic [31:0] hold_pc;
  logic [31:0] hold_ins;

  always @(negedge clock) begin
    if (!reset_n) begin
      model_pc   = 32'h0;
      model_mis  = 1'b0;
      model_halt = 1'b0;
      hold_pend  = 1'b0;
    end else begin
      if (imem_request_valid) begin
        chk("req_addr", imem_request_address, model_pc);
        chk("one_outstanding", 32'(outstanding), 32'd0);
      end
      if (instruction_valid) begin
        chk("pc", pc, model_pc);
        chk("instruction", instruction, word_at(model_pc));
        n_valid++;
      end
      chk("fetch_misaligned", 32'(fetch_misaligned), 32'(model_mis));
      if (model_halt)
        chk("halt_quiet",
            32'(imem_request_valid | instruction_valid), 32'd0);
      if (hold_pend) begin
        chk("hold_valid", 32'(instruction_valid), 32'd1);
        chk("hold_pc", pc, hold_pc);
        chk("hold_instr", instruction, hold_ins);
      end
      hold_pend = instruction_valid && !instruction_ready && !next_pc_valid;
      hold_pc   = pc;
      hold_ins  = instruction;
      if (instruction_valid && instruction_ready && !next_pc_valid)
        cons_log.push_back(pc);
      if (!model_halt) begin
        if (next_pc_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          model_pc = next_pc;
          if (next_pc[1:0] != 2'b00) begin
            model_mis  = 1'b1;
            model_halt = 1'b1;
          end
`else
          model_pc = {next_pc[31:2], 2'b00};
`endif
        end else if (instruction_valid && instruction_ready) begin
          model_pc = model_pc + 32'd4;
        end
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    next_pc_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    req_log.delete();
    cons_log.delete();
    w_req_log.delete();
    n_valid = 0;
    reset_n = 1'b1;
  endtask

  task automatic wait_reqs(input int n, input int budget);
    int i = 0;
    while (req_log.size() < n && i < budget) begin
      @(posedge clock);
      #1;
      i++;
    end
    if (req_log.size() < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_reqs: got %0d requests required %0d", req_log.size(), n);
    end
  endtask

  task automatic wait_valid(input int budget);
    int i = 0;
    while (!instruction_valid && i < budget) begin
      @(posedge clock);
      #1;
      i++;
    end
    if (!instruction_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_valid: got 0 required 1");
    end
  endtask

  task automatic redirect_pulse(input logic [31:0] target);
    next_pc_valid = 1'b1;
    next_pc = target;
    @(posedge clock);
    #1;
    next_pc_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    imem_request_ready = 1'b1;
    instruction_ready = 1'b1;
    next_pc_valid = 1'b0;
    next_pc = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req_valid", 32'(imem_request_valid), 32'd0);
    chk("rst_instr_valid", 32'(instruction_valid), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instruction, 32'h0000_0013);
    chk("rst_misaligned", 32'(fetch_misaligned), 32'd0);
    chk("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);

    // Sequential fetch, k=1, ALU always ready
    do_reset();
    @(posedge clock);
    #1;
    chk("seq_c1_req", 32'(imem_request_valid), 32'd1);
    chk("seq_c1_valid", 32'(instruction_valid), 32'd0);
    @(posedge clock);
    #1;
    chk("seq_c2_valid", 32'(instruction_valid), 32'd0);
    @(posedge clock);
    #1;
    chk("seq_c3_valid", 32'(instruction_valid), 32'd1);
    chk("seq_c3_pc", pc, 32'h0);
    chk("seq_c3_instr", instruction, 32'h5A5A_0000);
    wait_reqs(3, 40);
    repeat (4) @(posedge clock);
    #1;
    chk("seq_req0", qat(req_log, 0), 32'h0);
    chk("seq_req1", qat(req_log, 1), 32'h4);
    chk("seq_req2", qat(req_log, 2), 32'h8);
    chk("seq_cons0", qat(cons_log, 0), 32'h0);
    chk("seq_cons1", qat(cons_log, 1), 32'h4);
    chk("seq_cons2", qat(cons_log, 2), 32'h8);
    chk("wrap_req0", qat(w_req_log, 0), 32'hFFFF_FFFC);
    chk("wrap_req1", qat(w_req_log, 1), 32'h0000_0000);

    // ALU stalls 5 cycles in HOLD
    instruction_ready = 1'b0;
    do_reset();
    wait_valid(20);
    repeat (5) begin
      @(posedge clock);
      #1;
      chk("stall_valid", 32'(instruction_valid), 32'd1);
      chk("stall_pc", pc, 32'h0);
      chk("stall_instr", instruction, 32'h5A5A_0000);
      chk("stall_no_req", 32'(imem_request_valid), 32'd0);
    end
    chk("stall_req_count", 32'(req_log.size()), 32'd1);
    instruction_ready = 1'b1;
    wait_reqs(2, 20);
    chk("stall_next_req", qat(req_log, 1), 32'h4);

    // Redirect while waiting, stale response 2 cycles later
    mem_lat = 3;
    do_reset();
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    chk("wait_no_req", 32'(imem_request_valid), 32'd0);
    redirect_pulse(32'h100);
    wait_reqs(2, 30);
    chk("stale_req1", qat(req_log, 1), 32'h100);
    chk("stale_no_valid", 32'(n_valid), 32'd0);
    wait_valid(30);
    chk("stale_new_pc", pc, 32'h100);
    chk("stale_new_instr", instruction, 32'h5A5A_0100);
    mem_lat = 1;

    // Redirect has priority over consume in HOLD
    do_reset();
    wait_valid(20);
    redirect_pulse(32'h200);
    chk("hold_redir_valid", 32'(instruction_valid), 32'd0);
    wait_reqs(2, 20);
    chk("hold_redir_req1", qat(req_log, 1), 32'h200);

    // Misaligned redirect
    do_reset();
    wait_valid(20);
    redirect_pulse(32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_flag", 32'(fetch_misaligned), 32'd1);
    chk("mis_pc", pc, 32'h102);
    repeat (10) @(posedge clock);
    #1;
    chk("mis_no_req", 32'(req_log.size()), 32'd1);
    chk("mis_req_valid", 32'(imem_request_valid), 32'd0);
    chk("mis_instr_valid", 32'(instruction_valid), 32'd0);
    chk("mis_sticky", 32'(fetch_misaligned), 32'd1);
`else
    chk("mis_flag", 32'(fetch_misaligned), 32'd0);
    wait_reqs(2, 20);
    chk("mis_req1", qat(req_log, 1), 32'h100);
`endif
    repeat (2) @(posedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
